// File: rtl/gobang_board_pkg.sv
// rtl/gobang_board_pkg.sv - shared constants, FSM state type and helpers for the gobang board store
//
// Purpose: board geometry, window layout, colour encoding, FSM state type,
//          flat cell-index helper and the run-of-WIN_LEN detector.
// Ports:   none (package).
package gobang_board_pkg;

  localparam int BOARD_SIZE = 15;
  localparam int WIN_LEN    = 5;
  localparam int WIN_SIZE   = 9;
  localparam int WIN_CTR    = 4;
  localparam int CELLS      = BOARD_SIZE * BOARD_SIZE;
  localparam int IDX_W      = $clog2(CELLS);
  localparam int COORD_W    = 4;
  localparam int COUNT_W    = 8;

  localparam logic COLOR_BLACK = 1'b0;
  localparam logic COLOR_WHITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Planes are flat vectors; cell (i, j) lives at bit i*BOARD_SIZE+j.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] i,
                                                 input logic [COORD_W-1:0] j);
    return IDX_W'(int'(i) * BOARD_SIZE + int'(j));
  endfunction

  // True when the window holds WIN_LEN consecutive set bits anywhere.
  function automatic logic has_run(input logic [WIN_SIZE-1:0] w);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k <= WIN_SIZE - WIN_LEN; k++) begin
      if (&w[k +: WIN_LEN]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/gobang_board_line_window.sv
// rtl/gobang_board_line_window.sv - four 9-cell line windows of one plane around (i, j)
//
// Purpose: purely combinational window extraction; off-board cells read 0.
//          Bit k covers offset d = k - WIN_CTR, so bit WIN_CTR is (i, j) itself.
// Ports:
//   plane   in   CELLS     occupancy plane, bit i*BOARD_SIZE+j
//   i, j    in   COORD_W   window centre
//   win_i   out  WIN_SIZE  row            (i,   j+d)
//   win_j   out  WIN_SIZE  column         (i+d, j)
//   win_ij  out  WIN_SIZE  main diagonal  (i+d, j+d)
//   win_ji  out  WIN_SIZE  counter diag   (i+d, j-d)
module gobang_board_line_window
  import gobang_board_pkg::*;
(
  input  logic [CELLS-1:0]    plane,
  input  logic [COORD_W-1:0]  i,
  input  logic [COORD_W-1:0]  j,
  output logic [WIN_SIZE-1:0] win_i,
  output logic [WIN_SIZE-1:0] win_j,
  output logic [WIN_SIZE-1:0] win_ij,
  output logic [WIN_SIZE-1:0] win_ji
);

  function automatic logic cell_at(input logic [CELLS-1:0] p, input int r, input int c);
    logic [IDX_W-1:0] idx;
    if (r < 0 || r >= BOARD_SIZE || c < 0 || c >= BOARD_SIZE) return 1'b0;
    idx = IDX_W'(r * BOARD_SIZE + c);
    return p[idx];
  endfunction

  always_comb begin
    int ri;
    int cj;
    int d;
    win_i  = '0;
    win_j  = '0;
    win_ij = '0;
    win_ji = '0;
    ri = int'(i);
    cj = int'(j);
    for (int k = 0; k < WIN_SIZE; k++) begin
      d = k - WIN_CTR;
      win_i[k]  = cell_at(plane, ri,     cj + d);
      win_j[k]  = cell_at(plane, ri + d, cj);
      win_ij[k] = cell_at(plane, ri + d, cj + d);
      win_ji[k] = cell_at(plane, ri + d, cj - d);
    end
  end

endmodule

// File: rtl/gobang_board.sv
// rtl/gobang_board.sv - 15x15 two-plane board store with move handshake and win detect
//
// Purpose: holds black/white occupancy planes, accepts moves over put_valid/put_ready,
//          rejects off-board or occupied cells, detects five-in-a-row, counts stones,
//          and serves line windows around (get_i, get_j).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               synchronous new-game clear
//   put_valid/ready   move handshake; ready only in IDLE without win/full
//   put_color/i/j     mover colour (0 black, 1 white) and cell
//   put_ack/put_err   one-cycle outcome pulses
//   get_i/get_j       scan position for the window outputs
//   black_*/white_*   row/col/diag/anti-diag windows of each plane
//   win/winner        latched five-in-a-row flag and the colour that made it
//   move_count/full   stones on board, and board-full flag
module gobang_board
  import gobang_board_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                put_valid,
  output logic                put_ready,
  input  logic                put_color,
  input  logic [COORD_W-1:0]  put_i,
  input  logic [COORD_W-1:0]  put_j,
  output logic                put_ack,
  output logic                put_err,
  input  logic [COORD_W-1:0]  get_i,
  input  logic [COORD_W-1:0]  get_j,
  output logic [WIN_SIZE-1:0] black_i,
  output logic [WIN_SIZE-1:0] black_j,
  output logic [WIN_SIZE-1:0] black_ij,
  output logic [WIN_SIZE-1:0] black_ji,
  output logic [WIN_SIZE-1:0] white_i,
  output logic [WIN_SIZE-1:0] white_j,
  output logic [WIN_SIZE-1:0] white_ij,
  output logic [WIN_SIZE-1:0] white_ji,
  output logic                win,
  output logic                winner,
  output logic [COUNT_W-1:0]  move_count,
  output logic                full
);

  state_t state;
  state_t state_next;

  logic [CELLS-1:0]   black_plane;
  logic [CELLS-1:0]   white_plane;
  logic               lat_color;
  logic [COORD_W-1:0] lat_i;
  logic [COORD_W-1:0] lat_j;

  logic do_write;
  logic do_check;

  // Request qualification, evaluated on the live put_* inputs in IDLE.
  logic [IDX_W-1:0] put_idx;
  logic [IDX_W-1:0] lat_idx;
  logic             put_off;
  logic             put_bad;
  logic             accept;

  assign put_idx = cell_idx(put_i, put_j);
  assign lat_idx = cell_idx(lat_i, lat_j);
  assign put_off = (put_i > COORD_W'(BOARD_SIZE - 1)) || (put_j > COORD_W'(BOARD_SIZE - 1));
  // put_idx may point past the plane when off-board; put_off masks that read.
  assign put_bad = put_off || black_plane[put_idx] || white_plane[put_idx];
  assign accept  = put_valid && put_ready;
  assign full    = (move_count == COUNT_W'(CELLS));

  // Scan windows for the strategy.
  gobang_board_line_window u_get_black (
    .plane (black_plane), .i (get_i), .j (get_j),
    .win_i (black_i), .win_j (black_j), .win_ij (black_ij), .win_ji (black_ji)
  );

  gobang_board_line_window u_get_white (
    .plane (white_plane), .i (get_i), .j (get_j),
    .win_i (white_i), .win_j (white_j), .win_ij (white_ij), .win_ji (white_ji)
  );

  // Windows at the latched move, used only in CHECK.
  logic [WIN_SIZE-1:0] cb_i, cb_j, cb_ij, cb_ji;
  logic [WIN_SIZE-1:0] cw_i, cw_j, cw_ij, cw_ji;
  logic                hit;

  gobang_board_line_window u_chk_black (
    .plane (black_plane), .i (lat_i), .j (lat_j),
    .win_i (cb_i), .win_j (cb_j), .win_ij (cb_ij), .win_ji (cb_ji)
  );

  gobang_board_line_window u_chk_white (
    .plane (white_plane), .i (lat_i), .j (lat_j),
    .win_i (cw_i), .win_j (cw_j), .win_ij (cw_ij), .win_ji (cw_ji)
  );

  always_comb begin
    hit = 1'b0;
    if (lat_color == COLOR_WHITE) begin
      hit = has_run(cw_i) || has_run(cw_j) || has_run(cw_ij) || has_run(cw_ji);
    end else begin
      hit = has_run(cb_i) || has_run(cb_j) || has_run(cb_ij) || has_run(cb_ji);
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (accept && !put_bad) state_next = ST_WRITE;
      ST_WRITE: state_next = ST_CHECK;
      ST_CHECK: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    put_ready = 1'b0;
    do_write  = 1'b0;
    do_check  = 1'b0;
    unique case (state)
      ST_IDLE:  put_ready = !win && !full;
      ST_WRITE: do_write  = 1'b1;
      ST_CHECK: do_check  = 1'b1;
      default:  ;
    endcase
  end

  // Board, move latch, pulses and game status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      black_plane <= '0;
      white_plane <= '0;
      lat_color   <= 1'b0;
      lat_i       <= '0;
      lat_j       <= '0;
      put_ack     <= 1'b0;
      put_err     <= 1'b0;
      win         <= 1'b0;
      winner      <= 1'b0;
      move_count  <= '0;
    end else if (clr) begin
      black_plane <= '0;
      white_plane <= '0;
      lat_color   <= 1'b0;
      lat_i       <= '0;
      lat_j       <= '0;
      put_ack     <= 1'b0;
      put_err     <= 1'b0;
      win         <= 1'b0;
      winner      <= 1'b0;
      move_count  <= '0;
    end else begin
      put_ack <= 1'b0;
      put_err <= 1'b0;
      if (accept) begin
        lat_color <= put_color;
        lat_i     <= put_i;
        lat_j     <= put_j;
        put_err   <= put_bad;
      end
      if (do_write) begin
        if (lat_color == COLOR_BLACK) begin
          black_plane[lat_idx] <= 1'b1;
        end else begin
          white_plane[lat_idx] <= 1'b1;
        end
        move_count <= move_count + COUNT_W'(1);
      end
      if (do_check) begin
        put_ack <= 1'b1;
        if (hit) begin
          win    <= 1'b1;
          winner <= lat_color;
        end
      end
    end
  end

endmodule

// File: tb/tb_gobang_board.sv
// tb/tb_gobang_board.sv - self-checking bench for gobang_board
module tb_gobang_board;

  localparam int BS = 15;

  logic       clk = 1'b0;
  logic       rst, clr, put_valid, put_color;
  logic [3:0] put_i, put_j, get_i, get_j;
  logic       put_ready, put_ack, put_err, win, winner, full;
  logic [8:0] black_i, black_j, black_ij, black_ji;
  logic [8:0] white_i, white_j, white_ij, white_ji;
  logic [7:0] move_count;

  gobang_board dut (
    .clk (clk), .rst (rst), .clr (clr),
    .put_valid (put_valid), .put_ready (put_ready), .put_color (put_color),
    .put_i (put_i), .put_j (put_j), .put_ack (put_ack), .put_err (put_err),
    .get_i (get_i), .get_j (get_j),
    .black_i (black_i), .black_j (black_j), .black_ij (black_ij), .black_ji (black_ji),
    .white_i (white_i), .white_j (white_j), .white_ij (white_ij), .white_ji (white_ji),
    .win (win), .winner (winner), .move_count (move_count), .full (full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference board: 0 empty, 1 black, 2 white.
  int board [BS][BS];
  int m_count;
  bit m_win;
  bit m_winner;

  typedef struct {
    logic       c;
    logic [3:0] i;
    logic [3:0] j;
    int         res;   // 0 ack, 1 err, 2 ignored
    int         cnt;
    logic       w;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        board[r][c] = 0;
    m_count  = 0;
    m_win    = 1'b0;
    m_winner = 1'b0;
  endfunction

  function automatic logic [8:0] mwin(input int col, input int gi, input int gj, input int dir);
    int dr, dc, r, c;
    logic [8:0] w;
    case (dir)
      0:       begin dr = 0; dc = 1;  end
      1:       begin dr = 1; dc = 0;  end
      2:       begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    w = '0;
    for (int k = 0; k < 9; k++) begin
      r = gi + (k - 4) * dr;
      c = gj + (k - 4) * dc;
      if (r >= 0 && r < BS && c >= 0 && c < BS && board[r][c] == col) w[k] = 1'b1;
    end
    return w;
  endfunction

  // Length of the same-colour line through (r, c) along (dr, dc).
  function automatic int run_len(input int r, input int c, input int dr, input int dc);
    int n, col, rr, cc;
    col = board[r][c];
    n = 1;
    rr = r + dr; cc = c + dc;
    while (rr >= 0 && rr < BS && cc >= 0 && cc < BS && board[rr][cc] == col) begin
      n++; rr += dr; cc += dc;
    end
    rr = r - dr; cc = c - dc;
    while (rr >= 0 && rr < BS && cc >= 0 && cc < BS && board[rr][cc] == col) begin
      n++; rr -= dr; cc -= dc;
    end
    return n;
  endfunction

  task automatic check_windows(input logic [3:0] gi, input logic [3:0] gj);
    @(negedge clk);
    get_i = gi;
    get_j = gj;
    #1;
    chk("black_i",  black_i,  mwin(1, gi, gj, 0));
    chk("black_j",  black_j,  mwin(1, gi, gj, 1));
    chk("black_ij", black_ij, mwin(1, gi, gj, 2));
    chk("black_ji", black_ji, mwin(1, gi, gj, 3));
    chk("white_i",  white_i,  mwin(2, gi, gj, 0));
    chk("white_j",  white_j,  mwin(2, gi, gj, 1));
    chk("white_ij", white_ij, mwin(2, gi, gj, 2));
    chk("white_ji", white_ji, mwin(2, gi, gj, 3));
  endtask

  // One move request; predicts outcome from the model and compares. got = observed kind.
  task automatic apply_put(input logic c, input logic [3:0] i, input logic [3:0] j, output int got);
    int acks, errs, lat, exp_kind, exp_lat;
    bit m_ready;
    m_ready = !m_win && (m_count < BS * BS);
    if (!m_ready) begin
      exp_kind = 2; exp_lat = 0;
    end else if (i > 14 || j > 14 || board[i][j] != 0) begin
      exp_kind = 1; exp_lat = 1;
    end else begin
      exp_kind = 0; exp_lat = 3;
      board[i][j] = c ? 2 : 1;
      m_count++;
      if (run_len(i, j, 0, 1) >= 5 || run_len(i, j, 1, 0) >= 5 ||
          run_len(i, j, 1, 1) >= 5 || run_len(i, j, 1, -1) >= 5) begin
        m_win = 1'b1;
        m_winner = c;
      end
    end
    @(negedge clk);
    put_color = c; put_i = i; put_j = j; put_valid = 1'b1;
    chk("put_ready", put_ready, m_ready);
    acks = 0; errs = 0; lat = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      put_valid = 1'b0;
      if (put_ack) begin acks++; if (lat == 0) lat = n; end
      if (put_err) begin errs++; if (lat == 0) lat = n; end
    end
    chk("ack_count", acks, (exp_kind == 0) ? 1 : 0);
    chk("err_count", errs, (exp_kind == 1) ? 1 : 0);
    chk("latency", lat, exp_lat);
    chk("move_count", move_count, m_count);
    chk("win", win, m_win);
    chk("winner", winner, m_winner);
    got = (acks == 1 && errs == 0) ? 0 : (errs == 1 && acks == 0) ? 1 : (acks == 0 && errs == 0) ? 2 : 3;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    int acks;
    logic       rc;
    logic [3:0] ri, rj;

    tbl[0] = '{1'b0, 4'd7,  4'd7,  0, 1, 1'b0};
    tbl[1] = '{1'b1, 4'd7,  4'd7,  1, 1, 1'b0};
    tbl[2] = '{1'b1, 4'd15, 4'd3,  1, 1, 1'b0};
    tbl[3] = '{1'b1, 4'd3,  4'd15, 1, 1, 1'b0};
    tbl[4] = '{1'b0, 4'd0,  4'd0,  0, 2, 1'b0};
    tbl[5] = '{1'b0, 4'd1,  4'd1,  0, 3, 1'b0};
    tbl[6] = '{1'b0, 4'd2,  4'd2,  0, 4, 1'b0};
    tbl[7] = '{1'b0, 4'd3,  4'd3,  0, 5, 1'b0};
    tbl[8] = '{1'b0, 4'd4,  4'd4,  0, 6, 1'b1};
    tbl[9] = '{1'b0, 4'd5,  4'd5,  2, 6, 1'b1};

    rst = 1'b1; clr = 1'b0; put_valid = 1'b0; put_color = 1'b0;
    put_i = '0; put_j = '0; get_i = 4'd7; get_j = 4'd7;
    model_clear();
    #23;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_ready", put_ready, 1'b1);
    chk("rst_win", win, 1'b0);
    chk("rst_count", move_count, 8'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_ack", put_ack, 1'b0);
    chk("rst_err", put_err, 1'b0);
    check_windows(4'd7, 4'd7);

    // Directed table.
    for (int k = 0; k < 10; k++) begin
      apply_put(tbl[k].c, tbl[k].i, tbl[k].j, got);
      chk("tbl_result", got, tbl[k].res);
      chk("tbl_count", move_count, tbl[k].cnt);
      chk("tbl_win", win, tbl[k].w);
    end
    chk("tbl_winner", winner, 1'b0);
    chk("tbl_ready_after_win", put_ready, 1'b0);
    @(negedge clk);
    get_i = 4'd7; get_j = 4'd7;
    #1;
    chk("center_black_i", black_i, 9'b000010000);
    check_windows(4'd7, 4'd7);
    check_windows(4'd2, 4'd2);

    // Edge windows at the corner.
    do_clr();
    chk("clr_count", move_count, 8'd0);
    chk("clr_win", win, 1'b0);
    chk("clr_ready", put_ready, 1'b1);
    apply_put(1'b0, 4'd0, 4'd0, got);
    @(negedge clk);
    get_i = 4'd0; get_j = 4'd0;
    #1;
    chk("corner_black_i", black_i, 9'b000010000);
    chk("corner_black_j", black_j, 9'b000010000);
    chk("corner_black_ij", black_ij, 9'b000010000);
    chk("corner_white_ji", white_ji, 9'd0);
    check_windows(4'd0, 4'd0);

    // clr while the move is in WRITE aborts it.
    do_clr();
    @(negedge clk);
    put_color = 1'b0; put_i = 4'd3; put_j = 4'd3; put_valid = 1'b1;
    @(negedge clk);
    put_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    acks = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (put_ack || put_err) acks++;
    end
    chk("abort_no_pulse", acks, 0);
    chk("abort_count", move_count, 8'd0);
    check_windows(4'd3, 4'd3);
    apply_put(1'b1, 4'd3, 4'd3, got);
    chk("after_abort_put", got, 0);

    // Randomised games against the reference model.
    for (int g = 0; g < 4; g++) begin
      do_clr();
      for (int m = 0; m < 60; m++) begin
        rc = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 8) begin
          ri = 4'($urandom_range(0, 5));
          rj = 4'($urandom_range(0, 5));
        end else begin
          ri = 4'($urandom_range(0, 15));
          rj = 4'($urandom_range(0, 15));
        end
        apply_put(rc, ri, rj, got);
        check_windows(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        if (ri < 15 && rj < 15) check_windows(ri, rj);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
